// File: rtl/fetch_queue.sv
// 3-wide in-order fetch queue between fetch and dispatch, with per-slot back-pressure.
// Optional macro FETCH_QUEUE_SAME_CYCLE_FREE_EN lets slots dispatched this cycle be refilled in the same cycle.
package fetch_queue_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } IF_ID_PACKET;
endpackage

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int FQ_DEPTH = 8,
  parameter int FQ_PTR_W = $clog2(FQ_DEPTH),
  parameter int FQ_CNT_W = $clog2(FQ_DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                squash,
  input  IF_ID_PACKET [2:0]   if_packet_in,
  input  logic [1:0]          dis_num,
  output IF_ID_PACKET [2:0]   if_packet_out,
  output logic [2:0]          dis_stall,
  output logic [FQ_CNT_W-1:0] fq_count
);

  IF_ID_PACKET         entries_q [FQ_DEPTH];
  IF_ID_PACKET         entries_d [FQ_DEPTH];
  logic [FQ_PTR_W-1:0] head_q, head_d;
  logic [FQ_PTR_W-1:0] tail_q, tail_d;
  logic [FQ_CNT_W-1:0] count_q, count_d;
  logic [FQ_CNT_W-1:0] n_out;
  logic [FQ_CNT_W-1:0] free;
  logic [2:0]          accept;
  logic [1:0]          n_in;
  logic [FQ_PTR_W-1:0] wr_idx;
  logic [FQ_PTR_W-1:0] rd_idx;

  // Dispatch can never take more than is present, so an oversized dis_num is clamped.
  always_comb begin
    n_out = (FQ_CNT_W'(dis_num) < count_q) ? FQ_CNT_W'(dis_num) : count_q;
  end

  always_comb begin
`ifdef FETCH_QUEUE_SAME_CYCLE_FREE_EN
    free = FQ_CNT_W'(FQ_DEPTH) - count_q + n_out;
`else
    free = FQ_CNT_W'(FQ_DEPTH) - count_q;
`endif
  end

  assign dis_stall[2] = (free < FQ_CNT_W'(1));
  assign dis_stall[1] = (free < FQ_CNT_W'(2));
  assign dis_stall[0] = (free < FQ_CNT_W'(3));

  assign accept[2] = if_packet_in[2].valid && !dis_stall[2];
  assign accept[1] = if_packet_in[1].valid && !dis_stall[1];
  assign accept[0] = if_packet_in[0].valid && !dis_stall[0];
  assign n_in      = 2'(accept[2]) + 2'(accept[1]) + 2'(accept[0]);

  // Slot 2 is oldest and lands at tail; pointer arithmetic wraps since FQ_DEPTH is a power of two.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    wr_idx    = '0;
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        wr_idx = tail_q + FQ_PTR_W'(2 - i);
        if (accept[i]) begin
          entries_d[wr_idx] = if_packet_in[i];
        end
      end
      tail_d  = tail_q + FQ_PTR_W'(n_in);
      head_d  = head_q + FQ_PTR_W'(n_out);
      count_d = count_q + FQ_CNT_W'(n_in) - n_out;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clock) begin
    entries_q <= entries_d;
  end

  always_comb begin
    if_packet_out = '0;
    rd_idx        = '0;
    for (int k = 0; k < 3; k++) begin
      rd_idx = head_q + FQ_PTR_W'(2 - k);
      if (count_q > FQ_CNT_W'(2 - k)) begin
        if_packet_out[k] = entries_q[rd_idx];
      end
    end
  end

  assign fq_count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue, checked against a queue-based reference model.
// Honours FETCH_QUEUE_SAME_CYCLE_FREE_EN when the build defines it.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              clock = 1'b0;
  logic              reset;
  logic              squash;
  IF_ID_PACKET [2:0] if_packet_in;
  logic [1:0]        dis_num;
  IF_ID_PACKET [2:0] if_packet_out;
  logic [2:0]        dis_stall;
  logic [CNT_W-1:0]  fq_count;

  int          num_checks = 0;
  int          num_errors = 0;
  IF_ID_PACKET model_q[$];

  always #5 clock = ~clock;

  fetch_queue #(.FQ_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .squash       (squash),
    .if_packet_in (if_packet_in),
    .dis_num      (dis_num),
    .if_packet_out(if_packet_out),
    .dis_stall    (dis_stall),
    .fq_count     (fq_count)
  );

  task automatic compare(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    num_checks++;
    assert (obs === exp) else begin
      num_errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Free space as seen by fetch this cycle, from the model's occupancy.
  function automatic int model_free(input int dn);
    int f;
    f = DEPTH - model_q.size();
`ifdef FETCH_QUEUE_SAME_CYCLE_FREE_EN
    f += (dn < model_q.size()) ? dn : model_q.size();
`endif
    return f;
  endfunction

  task automatic checkOutput();
    int          f;
    logic [2:0]  exp_stall;
    IF_ID_PACKET exp_pkt;
    f = model_free(int'(dis_num));
    for (int k = 0; k < 3; k++) exp_stall[k] = (f < 3 - k);
    compare("fq_count", 128'(fq_count), 128'(model_q.size()));
    compare("dis_stall", 128'(dis_stall), 128'(exp_stall));
    for (int k = 2; k >= 0; k--) begin
      exp_pkt = '0;
      if ((2 - k) < model_q.size()) exp_pkt = model_q[2 - k];
      compare($sformatf("out[%0d]", k), 128'(if_packet_out[k]), 128'(exp_pkt));
    end
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, advance the model, then cross the posedge.
  task automatic applyStimulus(input bit rst, input bit sq, input int nvalid,
                               input logic [31:0] pc0, input logic [1:0] dn, input bit chk);
    int f;
    int n_out;
    @(negedge clock);
    reset   = rst;
    squash  = sq;
    dis_num = dn;
    for (int k = 2; k >= 0; k--) begin
      if_packet_in[k].valid = ((2 - k) < nvalid);
      if_packet_in[k].PC    = pc0 + 32'(4 * (2 - k));
      if_packet_in[k].NPC   = pc0 + 32'(4 * (3 - k));
      if_packet_in[k].inst  = $urandom;
    end
    #1;
    if (chk) checkOutput();
    if (rst || sq) begin
      model_q.delete();
    end else begin
      f     = model_free(int'(dn));
      n_out = (int'(dn) < model_q.size()) ? int'(dn) : model_q.size();
      repeat (n_out) void'(model_q.pop_front());
      for (int k = 2; k >= 0; k--) begin
        if (if_packet_in[k].valid && f > (2 - k)) model_q.push_back(if_packet_in[k]);
      end
    end
    @(posedge clock);
  endtask

  initial begin
    reset        = 1'b1;
    squash       = 1'b0;
    dis_num      = 2'd0;
    if_packet_in = '0;

    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // First group then idle: out slots show PC 0/4/8.
    applyStimulus(0, 0, 3, 32'h0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Fill to full; third group loses slot 0.
    applyStimulus(0, 0, 3, 32'h10, 0, 1);
    applyStimulus(0, 0, 3, 32'h20, 0, 1);
    #1;
    compare("full_count", 128'(fq_count), 128'(DEPTH));
    compare("full_stall", 128'(dis_stall), 128'(3'b111));
    applyStimulus(0, 0, 3, 32'h30, 0, 1);

    // Drain to 2, refill to 4, then enqueue 3 while dispatching 2.
    applyStimulus(0, 0, 0, 0, 3, 1);
    applyStimulus(0, 0, 0, 0, 3, 1);
    applyStimulus(0, 0, 2, 32'h40, 0, 1);
    applyStimulus(0, 0, 3, 32'h50, 2, 1);
    #1;
    compare("simul_count", 128'(fq_count), 128'(5));

    // Squash with 5 held and 3 arriving.
    applyStimulus(0, 1, 3, 32'h60, 1, 1);
    #1;
    compare("squash_count", 128'(fq_count), 128'(0));
    compare("squash_valid", 128'({if_packet_out[2].valid, if_packet_out[1].valid, if_packet_out[0].valid}), 128'(0));
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Park head and tail at 6, then enqueue across the wrap and drain.
    applyStimulus(0, 0, 3, 32'h70, 0, 1);
    applyStimulus(0, 0, 3, 32'h80, 0, 1);
    applyStimulus(0, 0, 0, 0, 3, 1);
    applyStimulus(0, 0, 0, 0, 3, 1);
    applyStimulus(0, 0, 3, 32'h100, 0, 1);
    applyStimulus(0, 0, 0, 0, 3, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Clamp: one entry, dispatch asks for three.
    applyStimulus(0, 0, 1, 32'h200, 0, 1);
    applyStimulus(0, 0, 0, 0, 3, 1);
    #1;
    compare("clamp_count", 128'(fq_count), 128'(0));
    applyStimulus(0, 0, 0, 0, 3, 1);

    // Full queue dispatching three while fetch offers three.
    applyStimulus(0, 0, 3, 32'h300, 0, 1);
    applyStimulus(0, 0, 3, 32'h310, 0, 1);
    applyStimulus(0, 0, 2, 32'h320, 0, 1);
    applyStimulus(0, 0, 3, 32'h330, 3, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Reset wins over squash.
    applyStimulus(1, 1, 3, 32'h400, 2, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    for (int c = 0; c < 600; c++) begin
      applyStimulus(0, ($urandom_range(0, 31) == 0), int'($urandom_range(0, 3)),
                    32'($urandom) & 32'hFFFF_FFFC, 2'($urandom_range(0, 3)), 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 1);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- 3-wide in-order instruction buffer between fetch_stage and dispatch.
- Absorbs up to 3 IF_ID_PACKETs per cycle from fetch and presents up to 3 oldest entries to dispatch.
- Generates per-slot dis_stall back to fetch, which then holds or re-fetches the unaccepted PCs.
- Flushed on branch recovery / squash.

Parameters:
- FQ_DEPTH, 8, number of entries; power of two, minimum 4.
- FQ_PTR_W, $clog2(FQ_DEPTH), width of the head/tail pointers.
- FQ_CNT_W, $clog2(FQ_DEPTH+1), width of the occupancy count.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- squash  input  1  flush all entries (branch recovery).
- if_packet_in  input  IF_ID_PACKET[2:0]  packets from fetch; slot 2 is oldest (lowest PC); valid bits form a prefix starting at slot 2.
- dis_num  input  2  number of entries dispatch takes this cycle (0..3), oldest first.
- if_packet_out  output  IF_ID_PACKET[2:0]  oldest three entries; slot 2 is the head.
- dis_stall  output  3  per-slot "cannot accept" to fetch_stage.dis_stall.
- fq_count  output  FQ_CNT_W  current occupancy (registered).

Behaviour:
- State: circular array of FQ_DEPTH packets, plus registered head, tail and count.
- Reset (sync, active-high): head=0, tail=0, count=0.
  - All if_packet_out valid=0; inst/PC/NPC fields 0.
  - dis_stall=3'b000; fq_count=0.
- Free space free = FQ_DEPTH - count, computed from the registered count only.
- dis_stall: [2] = (free<1), [1] = (free<2), [0] = (free<3).
- Accepted slot i: if_packet_in[i].valid && !dis_stall[i].
- n_in = number of accepted slots (0..3). Accepted slots are written at tail, tail+1, tail+2 in order 2,1,0; pointers wrap modulo FQ_DEPTH.
- Invalid slots are never written, even if slots below them are valid (fetch guarantees a contiguous prefix; the queue does not repair gaps).
- Output slot k (k=2,1,0, offset j=2-k):
  - if_packet_out[k] = entry[(head+j) mod FQ_DEPTH].
  - valid = (count > j); otherwise valid=0 and fields 0.
- n_out = min(dis_num, count, 3).
  - dis_num above the number of valid outputs is clamped, not an error.
  - head advances by n_out.
- count_next = count + n_in - n_out. Enqueue and dequeue in the same cycle are both honoured.
- Latency: a packet accepted in cycle N appears at if_packet_out no earlier than cycle N+1. No fetch-to-dispatch bypass.
- Full (count=FQ_DEPTH): dis_stall=3'b111 and no writes. Simultaneous dequeue does not open space until the next cycle (unless the optional feature is enabled).
- Empty (count=0): all outputs invalid; dis_num ignored.
- Wrap-around: head/tail crossing FQ_DEPTH-1 → 0 within one multi-entry enqueue/dequeue must preserve order.
- squash (priority over enqueue/dequeue):
  - Next cycle head=tail=count=0.
  - Packets presented during the squash cycle are dropped.
  - Outputs in the squash cycle are still driven from the current state; dispatch must ignore them.
- reset has priority over squash.
- Invariant: count never exceeds FQ_DEPTH; head/tail are consistent with count.

Optional Feature:
- Macro: FETCH_QUEUE_SAME_CYCLE_FREE_EN.
- Defined: free = FQ_DEPTH - count + n_out, so entries dispatched this cycle can be refilled in the same cycle.
  - Creates a combinational path dis_num → dis_stall → fetch_stage next_PC.
  - count_next formula is unchanged; a full queue with dis_num=3 accepts 3 new packets.
- Undefined: free uses the registered count only, as above.

Test Plan:
- Reset then idle → fq_count=0, dis_stall=000, all out valid=0; 3 valid packets PC 0/4/8 with dis_num=0 → next cycle fq_count=3, out[2].PC=0, out[1].PC=4, out[0].PC=8, all valid.
- Fill: FQ_DEPTH=8, send 3+3 packets then 3 more with dis_num=0 → third group: slots 2,1 accepted, slot 0 rejected (dis_stall=001); count=8, then dis_stall=111.
- Simultaneous: count=4, input 3 valid, dis_num=2 → count=5; out[2] = former third-oldest entry.
- Wrap-around: drive head=6, tail=6 (enqueue/dequeue 6), enqueue PC 0x100/0x104/0x108 → stored at indices 6,7,0; dequeue 3 → outputs in PC order, count=0.
- Clamp: count=1, dis_num=3 → head+1, count=0, no underflow; out valid 000.
- Squash with count=5 and 3 incoming valid packets → next cycle count=0, dis_stall=000, outputs invalid. With FETCH_QUEUE_SAME_CYCLE_FREE_EN: full queue, dis_num=3 → dis_stall=000 the same cycle, count stays 8.
